serial_alu: RTL
===============

SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter SLICE, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE, WIDTH >= 2 and SLICE >= 1; N = WIDTH/SLICE.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; accepted only in IDLE or DONE.
REQ-006 op  input  4  operation select, sampled with an accepted start.
REQ-007 a, b  input  WIDTH each  operands, sampled with an accepted start.
REQ-008 busy  output  1  high while a computation is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 result  output  WIDTH  result, held from the done cycle until the next accepted start.
REQ-011 zero, carry, overflow  output  1 each  flags, held with result.

Function
REQ-012 Op encoding: 0 AND, 1 OR, 2 ADD, 6 SUB (a-b), 7 SLT (signed), 12 NOR; every other code yields result 0 with all flags 0 except zero.
REQ-013 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE: start=1 -> latch op/a/b, clear slice index, carry-in := 1 for SUB/SLT, 0 otherwise, go to RUN; start=0 -> stay.
REQ-015 RUN: each cycle processes slice k (bits k*SLICE..k*SLICE+SLICE-1, LSB slice first) and forwards the slice carry to slice k+1; after slice N-1 go to DONE.
REQ-016 SUB/SLT use b inverted plus the initial carry-in of 1; ADD uses b unmodified.
REQ-017 DONE lasts exactly one cycle; start=1 -> behave as IDLE acceptance (back-to-back); start=0 -> go to IDLE.
REQ-018 Timing: start accepted in cycle 0 -> busy=1 in cycles 1..N, done=1 and busy=0 in cycle N+1; result/flags valid from cycle N+1.
REQ-019 start while in RUN SHALL be ignored with no effect on latched operands, state or outputs.
REQ-020 result and flags SHALL NOT change during RUN; they update only in the transition into DONE.
REQ-021 carry = carry out of bit WIDTH-1 for ADD/SUB (SUB: 1 means no borrow, i.e. a >= b unsigned); 0 for all other ops.
REQ-022 overflow = signed overflow of bit WIDTH-1 (carry into MSB XOR carry out) for ADD/SUB; 0 for all other ops.
REQ-023 SLT: result = {WIDTH-1 zeros, (MSB of a-b) XOR overflow(a-b)}; carry=0, overflow=0.
REQ-024 zero = 1 iff result equals 0, for every op including unused codes.
REQ-025 Logic ops (AND/OR/NOR) SHALL still take the full N-cycle latency.
REQ-026 The block SHALL use a single SLICE-bit datapath reused per cycle, not a full-width adder.

Reset
REQ-027 rst=1 at a clock edge -> state IDLE, busy=0, done=0, result=0, zero=0, carry=0, overflow=0, slice index and internal carry cleared, regardless of state.
REQ-028 rst asserted mid-RUN SHALL abort the operation; no done pulse for the aborted operation.
REQ-029 rst has priority over start in the same cycle; start is not accepted.

Verification (WIDTH=32, SLICE=4, N=8)
REQ-030 ADD a=0xFFFFFFFF b=0x00000001, start cycle 0 -> busy cycles 1..8, done cycle 9, result=0x00000000, zero=1, carry=1, overflow=0.
REQ-031 SUB a=0x80000000 b=0x00000001 -> result=0x7FFFFFFF, carry=1, overflow=1, zero=0; SUB a=3 b=5 -> result=0xFFFFFFFE, carry=0, overflow=0.
REQ-032 SLT a=0x80000000 b=0x00000001 -> result=1; SLT a=0x7FFFFFFF b=0x80000000 -> result=0; SLT a=5 b=5 -> result=0, zero=1.
REQ-033 AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000; NOR 0,0 -> 0xFFFFFFFF; op=3 -> result=0, zero=1, done cycle 9.
REQ-034 Start ADD 1+2 cycle 0, start with a=9 b=9 in cycle 4 (ignored) -> result=3; start ADD 4+4 in the done cycle 9 -> busy cycles 10..17, done cycle 18, result=8; result holds 3 during cycles 10..17.
REQ-035 Start ADD cycle 0, rst=1 in cycle 4 -> from cycle 5 busy=0, result=0, all flags 0, no done in cycles 5..12; a new start after reset completes with normal N+1 latency.

Source files
------------

// File: rtl/serial_alu.sv
// serial_alu: bit-serial (slice-serial) ALU. One SLICE-bit datapath is reused
// for N = WIDTH/SLICE cycles, LSB slice first, with the slice carry forwarded
// between cycles. Result and flags update only on the transition into DONE.
module serial_alu #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, acc;
    logic [IDX_W-1:0]   idx;
    logic               cin;

    logic               accept, last, is_sub;
    logic [SLICE-1:0]   a_s, b_s, slice_res;
    logic [SLICE:0]     sum;
    logic               cout, c_msb;
    logic [WIDTH-1:0]   acc_next, res_final;
    logic               carry_final, ovf_final, sub_ovf;

    // A start is honoured only outside RUN; rst priority is applied in the registers.
    assign accept = start && (state != RUN);
    assign last   = (idx == IDX_W'(N - 1));
    assign is_sub = (op == OP_SUB) || (op == OP_SLT);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Single-slice datapath: low slice of the shifting operand registers.
    always_comb begin
        a_s      = a_q[SLICE-1:0];
        b_s      = b_q[SLICE-1:0];
        sum      = {1'b0, a_s} + {1'b0, b_s} + (SLICE+1)'(cin);
        cout     = sum[SLICE];
        // Carry into the slice MSB, recovered from the sum bit.
        c_msb    = a_s[SLICE-1] ^ b_s[SLICE-1] ^ sum[SLICE-1];
        case (op_q)
            OP_AND:                 slice_res = a_s & b_s;
            OP_OR:                  slice_res = a_s | b_s;
            OP_NOR:                 slice_res = ~(a_s | b_s);
            OP_ADD, OP_SUB, OP_SLT: slice_res = sum[SLICE-1:0];
            default:                slice_res = '0;
        endcase
        // New slice enters at the top; after N shifts acc holds the full word.
        acc_next = (acc >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
    end

    // Final result and flags, meaningful on the last slice only.
    always_comb begin
        res_final   = '0;
        carry_final = 1'b0;
        ovf_final   = 1'b0;
        sub_ovf     = c_msb ^ cout;
        case (op_q)
            OP_AND, OP_OR, OP_NOR: res_final = acc_next;
            OP_ADD, OP_SUB: begin
                res_final   = acc_next;
                carry_final = cout;
                ovf_final   = sub_ovf;
            end
            OP_SLT:  res_final = WIDTH'(acc_next[WIDTH-1] ^ sub_ovf);
            default: res_final = '0;
        endcase
    end

    // Operand latching, slice stepping and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            idx      <= '0;
            cin      <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= is_sub ? ~b : b;
            acc  <= '0;
            idx  <= '0;
            cin  <= is_sub;
        end else if (state == RUN) begin
            a_q <= a_q >> SLICE;
            b_q <= b_q >> SLICE;
            acc <= acc_next;
            cin <= cout;
            idx <= idx + IDX_W'(1);
            if (last) begin
                result   <= res_final;
                zero     <= (res_final == '0);
                carry    <= carry_final;
                overflow <= ovf_final;
            end
        end
    end

endmodule
